serial_two_bit_adder: RTL

- Multi-cycle WIDTH-bit adder that retires 2 operand bits per clock through a 2-bit ripple slice, with the carry held in a register between cycles.
- Sits directly upstream of, and drives, the 2-bit full-adder slice. Owns operand capture, digit sequencing, carry propagation across cycles and result hand-off.
- Trades latency (WIDTH/2 cycles) for a 2-bit-wide datapath.

---
 rtl/serial_two_bit_adder_pkg.sv | 15 +
 rtl/full_adder_gatelevel_module.sv | 20 ++
 rtl/two_bit_adder_slice.sv | 29 ++
 rtl/serial_two_bit_adder.sv | 104 ++++++++++
 4 files changed

// File: rtl/serial_two_bit_adder_pkg.sv
// Shared types and sizing helpers for the serial two-bit-per-cycle adder.
package serial_two_bit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the counter can represent STEPS itself.
  function automatic int cnt_width(input int steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/full_adder_gatelevel_module.sv
// One-bit full adder written as explicit gate equations.
module full_adder_gatelevel_module (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic a_xor_b;
  logic gen;
  logic prop;

  assign a_xor_b = a ^ b;
  assign sum     = a_xor_b ^ cin;
  assign gen     = a & b;
  assign prop    = a_xor_b & cin;
  assign cout    = gen | prop;

endmodule

// File: rtl/two_bit_adder_slice.sv
// Combinational 2-bit ripple slice; exposes the upper carry so it can be
// registered between digit cycles.
module two_bit_adder_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic c_mid;

  full_adder_gatelevel_module u_fa0 (
    .a    (a[0]),
    .b    (b[0]),
    .cin  (cin),
    .sum  (sum[0]),
    .cout (c_mid)
  );

  full_adder_gatelevel_module u_fa1 (
    .a    (a[1]),
    .b    (b[1]),
    .cin  (c_mid),
    .sum  (sum[1]),
    .cout (cout)
  );

endmodule

// File: rtl/serial_two_bit_adder.sv
// Multi-cycle WIDTH-bit adder retiring one 2-bit digit per clock.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding one digit per cycle, carry held in c
//   DONE  | result presented, waiting for out_ready
module serial_two_bit_adder
  import serial_two_bit_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("serial_two_bit_adder: WIDTH must be even and >= 2");
  end

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [1:0]       slice_sum;
  logic             slice_cout;

  two_bit_adder_slice u_slice (
    .a    (a_sh[1:0]),
    .b    (b_sh[1:0]),
    .cin  (c),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New digit enters at the top so after STEPS shifts digit 0 sits at bit 0.
  always_comb begin
    s_next = s_sh >> 2;
    s_next[WIDTH-1 -: 2] = slice_sum;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (cnt == LAST_STEP) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 2;
          b_sh <= b_sh >> 2;
          s_sh <= s_next;
          c    <= slice_cout;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset gating keeps the handshakes quiet for the whole reset window.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE) && !reset;
  assign sum       = s_sh;
  assign cout      = c;

endmodule
